// File: rtl/fib_sink_pkg.sv
// Shared types and constants for the Fibonacci stream sink and its checker.
package fib_sink_pkg;

  // Width of one generator sample.
  localparam int BYTE_W = 8;

  // Default FIFO depth (power of two, at least 2) and counter width.
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;

  // Checker progress: two priming samples, then steady-state checking.
  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    CHECK  = 2'd2
  } chk_state_t;

  // Next term of the mod-256 recurrence; the carry out is dropped on purpose.
  function automatic logic [BYTE_W-1:0] fib_next(input logic [BYTE_W-1:0] older,
                                                 input logic [BYTE_W-1:0] newer);
    logic [BYTE_W-1:0] sum;
    sum = older + newer;
    return sum;
  endfunction

endpackage

// File: rtl/fib_recurrence_checker.sv
// Watches every sample strobe and flags the first value that breaks
// x[n] = x[n-1] + x[n-2] (mod 256). The history always follows the real
// stream, so after a bad sample checking continues from the actual values.
module fib_recurrence_checker
  import fib_sink_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              seq_err,
  output logic [BYTE_W-1:0] err_value
);

  chk_state_t        state_reg;
  chk_state_t        state_next;
  logic [BYTE_W-1:0] prev1_reg;
  logic [BYTE_W-1:0] prev2_reg;
  logic              seq_err_reg;
  logic [BYTE_W-1:0] err_value_reg;

  // Decoded per-cycle actions produced by the output process.
  logic              load_prev1;
  logic              shift_prev2;
  logic              mismatch;

  // State register: reset returns to priming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PRIME0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: advance only on a sample strobe.
  always_comb begin
    state_next = state_reg;
    if (in_valid) begin
      case (state_reg)
        PRIME0:  state_next = PRIME1;
        PRIME1:  state_next = CHECK;
        CHECK:   state_next = CHECK;
        default: state_next = PRIME0;
      endcase
    end
  end

  // Output decode: which history registers move and whether the sample is bad.
  always_comb begin
    load_prev1  = 1'b0;
    shift_prev2 = 1'b0;
    mismatch    = 1'b0;
    if (in_valid) begin
      case (state_reg)
        PRIME0: begin
          load_prev1 = 1'b1;
        end
        PRIME1: begin
          load_prev1  = 1'b1;
          shift_prev2 = 1'b1;
        end
        CHECK: begin
          load_prev1  = 1'b1;
          shift_prev2 = 1'b1;
          mismatch    = (in_data != fib_next(prev2_reg, prev1_reg));
        end
        default: begin
          load_prev1 = 1'b0;
        end
      endcase
    end
  end

  // History registers: shift in every accepted sample, good or bad.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev1_reg <= '0;
      prev2_reg <= '0;
    end else begin
      if (load_prev1) begin
        prev1_reg <= in_data;
      end
      if (shift_prev2) begin
        prev2_reg <= prev1_reg;
      end
    end
  end

  // Sticky error flag; only the first offending sample is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_reg   <= 1'b0;
      err_value_reg <= '0;
    end else if (mismatch && !seq_err_reg) begin
      seq_err_reg   <= 1'b1;
      err_value_reg <= in_data;
    end
  end

  assign seq_err   = seq_err_reg;
  assign err_value = err_value_reg;

endmodule

// File: rtl/fib_stream_sink.sv
// Consumer of the 8-bit Fibonacci generator: checks the recurrence, buffers
// samples in a small FIFO with a valid/ready output, and keeps sticky status
// and saturating counters. It never back-pressures the generator; samples
// that arrive while the FIFO is full and not draining are dropped.
module fib_stream_sink
  import fib_sink_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              seq_err,
  output logic [BYTE_W-1:0] err_value,
  output logic              overflow,
  output logic [CNT_W-1:0]  acc_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // FIFO storage and bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally at their own width.
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;

  logic              overflow_reg;
  logic [CNT_W-1:0]  acc_count_reg;
  logic [CNT_W-1:0]  drop_count_reg;

  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // A full FIFO that is popped in the same cycle frees a slot for the sample.
  assign pop  = !empty && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Sample storage; no reset needed because empty entries are never shown.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow and saturating accept/drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg   <= 1'b0;
      acc_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (push && (acc_count_reg != '1)) begin
        acc_count_reg <= acc_count_reg + CNT_W'(1);
      end
      if (drop && (drop_count_reg != '1)) begin
        drop_count_reg <= drop_count_reg + CNT_W'(1);
      end
    end
  end

  // Head of the FIFO; forced to zero while empty so stale data never leaks.
  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem[rd_ptr_reg];
    end
  end

  assign out_valid  = !empty;
  assign overflow   = overflow_reg;
  assign acc_count  = acc_count_reg;
  assign drop_count = drop_count_reg;

  // The checker sees every strobe, including samples the FIFO drops.
  fib_recurrence_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .seq_err   (seq_err),
    .err_value (err_value)
  );

endmodule
